// File: rtl/fft_frame_buffer_pkg.sv
// Shared FMCW parameters and state encodings for the FFT frame buffer.
// Imported by the frame buffer top and its storage bank.
package fft_frame_buffer_pkg;

  localparam int FB_OW    = 14;
  localparam int FB_NSAMP = 1000;
  localparam int FB_FFT_N = 1024;
  localparam int FB_AW    = 10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FILL,
    WR_DROP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_e;

  // Read beat in flight between the RAM read and the output register.
  typedef struct packed {
    logic vld;
    logic pad;
    logic last;
  } rd_beat_t;

endpackage

// File: rtl/fft_buf_bank.sv
// Two-bank sample store for the FFT frame buffer.
// One write port, one read port with a registered read.
module fft_buf_bank
  import fft_frame_buffer_pkg::*;
#(
  parameter int OW    = FB_OW,
  parameter int NSAMP = FB_NSAMP,
  parameter int AW    = FB_AW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [OW-1:0] wdata_i,
  input  logic          re_i,
  input  logic          rbank_i,
  input  logic [AW-1:0] raddr_i,
  output logic [OW-1:0] rdata_o
);

  localparam int DEPTH = 2 * NSAMP;
  localparam int LW    = $clog2(DEPTH);
  localparam logic [LW-1:0] BANK_OFS = LW'(NSAMP);

  logic [OW-1:0] mem_q [DEPTH];
  logic [OW-1:0] rdata_q;
  logic [LW-1:0] wlin;
  logic [LW-1:0] rlin;

  // Bank 1 sits directly above bank 0, so the array is exactly 2*NSAMP deep.
  always_comb begin
    wlin = LW'(waddr_i);
    rlin = LW'(raddr_i);
    if (wbank_i) wlin = BANK_OFS + LW'(waddr_i);
    if (rbank_i) rlin = BANK_OFS + LW'(raddr_i);
  end

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wlin] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[rlin];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong chirp frame buffer between the Kaiser window and the FFT.
// Fills NSAMP samples per frame and streams FFT_N zero-padded beats.
module fft_frame_buffer
  import fft_frame_buffer_pkg::*;
#(
  parameter int OW    = FB_OW,
  parameter int NSAMP = FB_NSAMP,
  parameter int FFT_N = FB_FFT_N,
  parameter int AW    = FB_AW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [OW-1:0] data_i,
  input  logic          valid_i,
  input  logic          sof_i,
  output logic [OW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          last_o,
  output logic          overflow_o,
  output logic          frame_err_o
);

  localparam logic [AW-1:0] WLAST = AW'(NSAMP - 1);
  localparam logic [AW-1:0] RLAST = AW'(FFT_N - 1);
  localparam logic [AW-1:0] ONE   = AW'(1);

  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  wr_state_e     wr_state_q, wr_state_d;
  rd_state_e     rd_state_q, rd_state_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    full_q, full_d;
  logic          done_q, done_d;
  rd_beat_t      s1_q, s1_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [OW-1:0] data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic          set_full;
  logic          clr_full;
  logic          wr_empty;
  logic          iss_en;
  logic          iss_bank;
  logic [AW-1:0] iss_idx;
  logic          re;
  logic          adv;
  logic          rd_free;
  logic [OW-1:0] rdata;

  assign adv     = !valid_q || ready_i;
  assign rd_free = valid_q && last_q && ready_i;
  // A bank released by the reader this cycle may be claimed at once.
  assign wr_empty = !full_q[wr_bank_q] ||
                    (rd_free && (rd_bank_q == wr_bank_q));

  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    we         = 1'b0;
    waddr      = wr_addr_q;
    set_full   = 1'b0;
    ovf_d      = 1'b0;
    ferr_d     = 1'b0;
    unique case (wr_state_q)
      WR_IDLE, WR_DROP: begin
        if (valid_i && sof_i) begin
          if (wr_empty) begin
            we         = 1'b1;
            waddr      = '0;
            wr_addr_d  = ONE;
            wr_state_d = WR_FILL;
          end else begin
            ovf_d      = 1'b1;
            wr_state_d = WR_DROP;
          end
        end
      end
      WR_FILL: begin
        if (valid_i) begin
          we = 1'b1;
          if (sof_i) begin
            ferr_d    = 1'b1;
            waddr     = '0;
            wr_addr_d = ONE;
          end else if (wr_addr_q == WLAST) begin
            set_full   = 1'b1;
            wr_bank_d  = !wr_bank_q;
            wr_addr_d  = '0;
            wr_state_d = WR_IDLE;
          end else begin
            wr_addr_d = wr_addr_q + ONE;
          end
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    idx_d      = idx_q;
    done_d     = done_q;
    clr_full   = 1'b0;
    iss_en     = 1'b0;
    iss_bank   = rd_bank_q;
    iss_idx    = idx_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          iss_en     = 1'b1;
          iss_idx    = '0;
          idx_d      = ONE;
          done_d     = 1'b0;
          rd_state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (rd_free) begin
          clr_full  = 1'b1;
          rd_bank_d = !rd_bank_q;
          iss_bank  = !rd_bank_q;
          // Chain straight into the other bank: costs one bubble beat.
          if (full_q[!rd_bank_q]) begin
            iss_en  = 1'b1;
            iss_idx = '0;
            idx_d   = ONE;
            done_d  = 1'b0;
          end else begin
            rd_state_d = RD_IDLE;
          end
        end else if (!done_q && adv) begin
          iss_en = 1'b1;
          if (idx_q == RLAST) done_d = 1'b1;
          else idx_d = idx_q + ONE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign re = iss_en && (iss_idx <= WLAST);

  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[rd_bank_q] = 1'b0;
    if (set_full) full_d[wr_bank_q] = 1'b1;
  end

  // The pipeline only moves when the output slot is free or draining.
  always_comb begin
    s1_d    = s1_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (adv) begin
      s1_d.vld  = iss_en;
      s1_d.pad  = iss_idx > WLAST;
      s1_d.last = iss_idx == RLAST;
      valid_d   = s1_q.vld;
      last_d    = s1_q.vld && s1_q.last;
      data_d    = (s1_q.vld && !s1_q.pad) ? rdata : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      idx_q      <= '0;
      full_q     <= '0;
      done_q     <= 1'b0;
      s1_q       <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_addr_q  <= wr_addr_d;
      idx_q      <= idx_d;
      full_q     <= full_d;
      done_q     <= done_d;
      s1_q       <= s1_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end

  fft_buf_bank #(
    .OW    (OW),
    .NSAMP (NSAMP),
    .AW    (AW)
  ) u_bank (
    .clk_i   (clk_i),
    .we_i    (we),
    .wbank_i (wr_bank_q),
    .waddr_i (waddr),
    .wdata_i (data_i),
    .re_i    (re),
    .rbank_i (iss_bank),
    .raddr_i (iss_idx),
    .rdata_o (rdata)
  );

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign last_o      = last_q;
  assign overflow_o  = ovf_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: framing, zero pad,
// back-pressure, overflow, frame error, gaps and reset.
module tb_fft_frame_buffer;

  localparam int OW    = 14;
  localparam int NSAMP = 1000;
  localparam int FFT_N = 1024;
  localparam int AW    = 10;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [OW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          sof_i = 1'b0;
  logic [OW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          last_o;
  logic          overflow_o;
  logic          frame_err_o;

  fft_frame_buffer #(
    .OW    (OW),
    .NSAMP (NSAMP),
    .FFT_N (FFT_N),
    .AW    (AW)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .sof_i       (sof_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o),
    .overflow_o  (overflow_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    int            k;
    logic [OW-1:0] d;
    logic          l;
  } vec_t;

  beat_t         got_q[$];
  logic [OW-1:0] cap_d [FFT_N];
  logic          cap_l [FFT_N];
  vec_t          tbl [11];

  int chk = 0;
  int err = 0;
  int ovf_cnt = 0;
  int ferr_cnt = 0;
  int rdy_mode = 0;

  logic          stall_prev = 1'b0;
  logic [OW-1:0] pd = '0;
  logic          pl = 1'b0;

  // Sample mid-low-phase: inputs settled, outputs stable since the edge.
  always @(negedge clk_i) begin
    #3;
    if (rst_n_i) begin
      if (stall_prev) begin
        chk++;
        if (!valid_o || data_o !== pd || last_o !== pl) begin
          err++;
          $display("FAIL stall_hold: got v=%0b d=%0d l=%0b need v=1 d=%0d l=%0b",
                   valid_o, data_o, last_o, pd, pl);
        end
      end
      if (valid_o && ready_i) got_q.push_back('{data_o, last_o});
      if (overflow_o) ovf_cnt++;
      if (frame_err_o) ferr_cnt++;
      stall_prev = valid_o && !ready_i;
      pd = data_o;
      pl = last_o;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk_i);
    case (rdy_mode)
      0: ready_i = 1'b1;
      1: ready_i = 1'($urandom_range(0, 1));
      default: ready_i = 1'b0;
    endcase
  endtask

  task automatic chk_eq(input string nm, input int got, input int exp);
    chk++;
    if (got != exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic send_frame(input int base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < gap; g++) begin
        tick();
        valid_i = 1'b0;
        sof_i = 1'b0;
      end
      tick();
      valid_i = 1'b1;
      sof_i = (i == 0);
      data_i = OW'(base + i);
    end
    tick();
    valid_i = 1'b0;
    sof_i = 1'b0;
    data_i = '0;
  endtask

  task automatic send_strays(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      valid_i = 1'b1;
      sof_i = 1'b0;
      data_i = OW'(base + i);
    end
    tick();
    valid_i = 1'b0;
  endtask

  task automatic check_frame(input int base, input string nm);
    int n;
    int bad;
    int bad_k;
    int lcnt;
    int lpos;
    beat_t b;
    logic [OW-1:0] exp;
    logic [OW-1:0] bad_got;
    logic [OW-1:0] bad_exp;
    n = 0;
    while (got_q.size() < FFT_N && n < 6000) begin
      tick();
      n++;
    end
    chk++;
    if (got_q.size() < FFT_N) begin
      err++;
      $display("FAIL %s_timeout: got %0d beats, need %0d",
               nm, got_q.size(), FFT_N);
      got_q.delete();
      return;
    end
    bad = 0;
    bad_k = -1;
    bad_got = '0;
    bad_exp = '0;
    lcnt = 0;
    lpos = -1;
    for (int k = 0; k < FFT_N; k++) begin
      b = got_q.pop_front();
      cap_d[k] = b.d;
      cap_l[k] = b.l;
      exp = (k < NSAMP) ? OW'(base + k) : '0;
      if (b.d !== exp) begin
        if (bad == 0) begin
          bad_k = k;
          bad_got = b.d;
          bad_exp = exp;
        end
        bad++;
      end
      if (b.l) begin
        lcnt++;
        lpos = k;
      end
    end
    chk++;
    if (bad != 0) begin
      err++;
      $display("FAIL %s_data: %0d bad beats, first k=%0d got %0d expected %0d",
               nm, bad, bad_k, bad_got, bad_exp);
    end
    chk++;
    if (lcnt != 1 || lpos != FFT_N - 1) begin
      err++;
      $display("FAIL %s_last: got %0d lasts at k=%0d, need 1 at k=%0d",
               nm, lcnt, lpos, FFT_N - 1);
    end
  endtask

  task automatic expect_quiet(input string nm, input int cyc);
    for (int i = 0; i < cyc; i++) tick();
    chk_eq(nm, got_q.size(), 0);
  endtask

  int run;
  int n;

  initial begin
    tbl[0]  = '{0,    14'd0,   1'b0};
    tbl[1]  = '{1,    14'd1,   1'b0};
    tbl[2]  = '{2,    14'd2,   1'b0};
    tbl[3]  = '{499,  14'd499, 1'b0};
    tbl[4]  = '{500,  14'd500, 1'b0};
    tbl[5]  = '{998,  14'd998, 1'b0};
    tbl[6]  = '{999,  14'd999, 1'b0};
    tbl[7]  = '{1000, 14'd0,   1'b0};
    tbl[8]  = '{1001, 14'd0,   1'b0};
    tbl[9]  = '{1022, 14'd0,   1'b0};
    tbl[10] = '{1023, 14'd0,   1'b1};

    rdy_mode = 2;
    for (int i = 0; i < 3; i++) tick();
    chk_eq("rst_valid", int'(valid_o), 0);
    chk_eq("rst_data", int'(data_o), 0);
    chk_eq("rst_last", int'(last_o), 0);
    chk_eq("rst_ovf", int'(overflow_o), 0);
    chk_eq("rst_ferr", int'(frame_err_o), 0);
    rst_n_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Single frame with ready held high: latency, gapless stream, content.
    rdy_mode = 0;
    send_frame(0, NSAMP, 1);
    chk_eq("lat_plus0", int'(valid_o), 0);
    tick();
    chk_eq("lat_plus1", int'(valid_o), 0);
    tick();
    chk_eq("lat_plus2", int'(valid_o), 1);
    chk_eq("first_data", int'(data_o), 0);
    run = 1;
    while (run < 1100) begin
      tick();
      if (!valid_o) break;
      run++;
    end
    chk_eq("gapless_run", run, FFT_N);
    check_frame(0, "single");
    for (int i = 0; i < 11; i++) begin
      chk_eq($sformatf("tbl_d_%0d", tbl[i].k),
             int'(cap_d[tbl[i].k]), int'(tbl[i].d));
      chk_eq($sformatf("tbl_l_%0d", tbl[i].k),
             int'(cap_l[tbl[i].k]), int'(tbl[i].l));
    end
    expect_quiet("single_extra", 20);

    // Random back-pressure.
    rdy_mode = 1;
    send_frame(3000, NSAMP, 1);
    check_frame(3000, "bp");
    expect_quiet("bp_extra", 20);

    // Both banks full, third frame must be dropped.
    rdy_mode = 2;
    ovf_cnt = 0;
    ferr_cnt = 0;
    send_frame(100, NSAMP, 1);
    send_frame(4000, NSAMP, 1);
    send_frame(8000, NSAMP, 1);
    for (int i = 0; i < 5; i++) tick();
    chk_eq("ovf_pulses", ovf_cnt, 1);
    chk_eq("ovf_no_ferr", ferr_cnt, 0);
    chk_eq("ovf_none_out", got_q.size(), 0);
    rdy_mode = 0;
    check_frame(100, "pp_a");
    check_frame(4000, "pp_b");
    expect_quiet("pp_c_dropped", 1200);

    // sof in the middle of a fill restarts the frame.
    ferr_cnt = 0;
    ovf_cnt = 0;
    send_frame(200, 500, 1);
    send_frame(6000, NSAMP, 1);
    for (int i = 0; i < 3; i++) tick();
    chk_eq("ferr_pulses", ferr_cnt, 1);
    chk_eq("ferr_no_ovf", ovf_cnt, 0);
    check_frame(6000, "ferr");
    expect_quiet("ferr_extra", 20);

    // Stray non-sof samples while idle, then a 1-in-3 gapped frame.
    send_strays(11000, 7);
    send_frame(9000, NSAMP, 3);
    check_frame(9000, "gap");
    expect_quiet("gap_extra", 20);
    chk_eq("gap_no_ferr", ferr_cnt, 1);

    // Reset in the middle of streaming.
    send_frame(1234, NSAMP, 1);
    n = 0;
    while (got_q.size() < 300 && n < 3000) begin
      tick();
      n++;
    end
    chk_eq("mid_reached", int'(got_q.size() >= 300), 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_eq("arst_valid", int'(valid_o), 0);
    chk_eq("arst_data", int'(data_o), 0);
    chk_eq("arst_last", int'(last_o), 0);
    got_q.delete();
    for (int i = 0; i < 3; i++) tick();
    rst_n_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_eq("post_rst_quiet", int'(valid_o), 0);
    send_frame(77, NSAMP, 1);
    check_frame(77, "post_rst");
    expect_quiet("post_rst_extra", 20);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Sits directly downstream of the Kaiser window stage, feeding the FFT.
- Collects one chirp of windowed samples (NSAMP per frame), zero-pads each frame to FFT_N points, and streams it out under a valid/ready handshake with a last flag.
- Ping-pong (two-bank) storage lets frame k+1 be written while frame k drains.

Parameters:
- OW, 14, sample width (matches windowed data width)
- NSAMP, 1000, valid samples per chirp frame
- FFT_N, 1024, output frame length; must satisfy FFT_N >= NSAMP
- AW, 10, address width; ceil(log2(FFT_N))

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- data_i  in  OW  windowed sample
- valid_i  in  1  data_i qualifier; no back-pressure on input
- sof_i  in  1  first sample of chirp; meaningful only with valid_i
- data_o  out  OW  frame sample to FFT
- valid_o  out  1  data_o valid
- ready_i  in  1  FFT accepts when valid_o & ready_i
- last_o  out  1  high with output index FFT_N-1
- overflow_o  out  1  one-cycle pulse: frame dropped, target bank still full
- frame_err_o  out  1  one-cycle pulse: sof_i arrived mid-frame, partial frame discarded

Behaviour:
- Reset (async assert, sync deassert internally): valid_o=0, data_o=0, last_o=0, overflow_o=0, frame_err_o=0. Both banks empty. Write bank=0, read bank=0. Write FSM=IDLE, read FSM=IDLE.
- Write FSM IDLE -> FILL on valid_i&sof_i when bank W is empty. The sof sample is written to addr 0.
- If bank W is full at that sof: pulse overflow_o, go to DROP, and ignore samples until the next sof.
- A bank freed by the read side in the same cycle counts as empty (free has priority).
- FILL: each valid_i writes addr 0..NSAMP-1 in order; cycles without valid_i hold the address.
- On the write of addr NSAMP-1: mark bank W full, toggle W, go to IDLE.
- Valid samples in IDLE without sof are discarded silently.
- sof_i in FILL at addr != 0: pulse frame_err_o, restart at addr 0 in the same bank with this sample. The bank is not marked full.
- Read FSM IDLE -> STREAM when bank R is full. Banks drain strictly in completion order.
- Latency: if the read side is idle, valid_o rises exactly 2 cycles after the cycle NSAMP-1 is written (1 cycle RAM read + output register).
- STREAM index k=0..FFT_N-1: data_o = RAM[k] for k<NSAMP, else 0. last_o is high only at k=FFT_N-1.
- A new index is presented only after a handshake. While valid_o & !ready_i, data_o and last_o are held stable.
- The RAM read is prefetched so that with ready_i held high, valid_o stays high for FFT_N consecutive cycles (no bubbles).
- On the handshake with last_o: bank R is marked empty, R toggles, and the FSM returns to IDLE.
- If the other bank is already full, valid_o stays high: STREAM re-enters with ≤1 bubble cycle (one is allowed).
- Zero-pad region never reads RAM; output is forced to 0.
- Reset mid-frame: all partial and full frames are lost, and outputs return to their reset values immediately.
- Width rules: data passes through unmodified (no arithmetic). Counters are AW bits and never wrap past FFT_N-1.

Decomposition:
- Shared package/defines:
  - OW, NSAMP, FFT_N, AW, added to the common FMCW parameter set.
  - Write-FSM state encoding (IDLE/FILL/DROP) and read-FSM encoding (IDLE/STREAM).
- One sub-module, fft_buf_bank: simple dual-port RAM, 2*NSAMP x OW.
  - Address = {bank, addr}; one write port; one read port with registered (1-cycle) read.
  - Infers block RAM.
- Top level holds both FSMs, bank full flags, counters and the output register/skid.

Test Plan:
- Single frame, ready_i=1: sof + 1000 samples value=index -> valid_o 2 cycles after last write; outputs 0..999, then 24 zeros; last_o only on the 1024th beat; no gaps.
- Back-pressure: ready_i toggled pseudo-randomly -> no sample lost or duplicated; data_o/last_o stable while stalled; 1024 beats total.
- Back-to-back frames with ready_i=0 until both banks are full, then a third sof -> overflow_o pulses once; the third frame is dropped; the first two drain in order with correct content.
- sof_i at sample 500 of a fill -> frame_err_o pulses once; the resulting frame starts with the new sof sample and has exactly 1000 samples.
- Gapped input (valid_i 1 in 3) plus non-sof samples while IDLE -> stray samples ignored; frame content correct.
- rst_n_i asserted mid-STREAM -> valid_o, last_o, data_o go to 0 asynchronously; after release, the next full frame streams correctly from index 0.
